// File: rtl/meter_display.sv
// meter_display: scans the counter's 4-digit BCD time across a
// common-anode seven-segment display and blinks it when time runs low.
module meter_display #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned HALF_SEC    = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] d,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned HW = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      LOW    = 2'd1,
      ZERO   = 2'd2
   } modeT;

   logic [SW-1:0] scanCnt;
   logic [1:0]    scanIdx;
   logic [HW-1:0] halfCnt;
   logic [1:0]    phase;
   modeT          modeReg;
   modeT          modeNext;
   logic [3:0]    nibble;
   logic [6:0]    segDec;
   logic [3:0]    anDec;
   logic          visible;

   // Blink class of the incoming time value
   always_comb begin
      modeNext = NORMAL;
      if (d == 16'h0000)
         modeNext = ZERO;
      else if (d[15:12] == 4'd0 && d[11:8] < 4'd2)
         modeNext = LOW;
   end

   // Select the digit for the current slot and decode it
   always_comb begin
      nibble = d[3:0];
      anDec  = 4'b1110;
      case (scanIdx)
         2'd0: begin nibble = d[3:0];   anDec = 4'b1110; end
         2'd1: begin nibble = d[7:4];   anDec = 4'b1101; end
         2'd2: begin nibble = d[11:8];  anDec = 4'b1011; end
         default: begin nibble = d[15:12]; anDec = 4'b0111; end
      endcase
      case (nibble)
         4'd0: segDec = 7'b1000000;
         4'd1: segDec = 7'b1111001;
         4'd2: segDec = 7'b0100100;
         4'd3: segDec = 7'b0110000;
         4'd4: segDec = 7'b0011001;
         4'd5: segDec = 7'b0010010;
         4'd6: segDec = 7'b0000010;
         4'd7: segDec = 7'b1111000;
         4'd8: segDec = 7'b0000000;
         4'd9: segDec = 7'b0010000;
         default: segDec = 7'b1111111;
      endcase
   end

   // Visibility follows the registered mode and blink phase
   always_comb begin
      case (modeReg)
         LOW:     visible = ~phase[1];
         ZERO:    visible = ~phase[0];
         default: visible = 1'b1;
      endcase
   end

   // Digit scan timing: slot counter and scan index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scanCnt <= '0;
         scanIdx <= '0;
      end else if (scanCnt == SW'(REFRESH_DIV - 1)) begin
         scanCnt <= '0;
         scanIdx <= scanIdx + 2'd1;
      end else begin
         scanCnt <= scanCnt + 1'b1;
      end
   end

   // Mode register and blink timebase; a mode change restarts the blink
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modeReg <= NORMAL;
         halfCnt <= '0;
         phase   <= '0;
      end else begin
         modeReg <= modeNext;
         if (modeReg != modeNext) begin
            halfCnt <= '0;
            phase   <= '0;
         end else if (halfCnt == HW'(HALF_SEC - 1)) begin
            halfCnt <= '0;
            phase   <= phase + 2'd1;
         end else begin
            halfCnt <= halfCnt + 1'b1;
         end
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= '1;
         dp  <= 1'b1;
      end else begin
         dp <= 1'b1;
         if (visible) begin
            an  <= anDec;
            seg <= segDec;
         end else begin
            an  <= '1;
            seg <= '1;
         end
      end
   end

endmodule

// File: tb/tb_meter_display.sv
// tb_meter_display: randomized and directed stimulus checked against a
// time-based reference model of scan slot and blink interval.
module tb_meter_display;

   localparam int unsigned R = 4;
   localparam int unsigned H = 20;

   logic        clk;
   logic        rst_n;
   logic [15:0] d;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int unsigned nChecks;
   int unsigned nErrors;

   // reference model state: edges since reset, edge of last blink restart,
   // registered blink class (0 normal, 1 low, 2 zero)
   int unsigned kEdge;
   int unsigned sEdge;
   int unsigned mReg;

   logic [6:0] segTbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};

   meter_display #(.REFRESH_DIV(R), .HALF_SEC(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned classOf(input logic [15:0] v);
      if (v == 16'h0000) return 2;
      if (v[15:12] == 4'd0 && v[11:8] < 4'd2) return 1;
      return 0;
   endfunction

   function automatic logic [15:0] bcd(input int unsigned n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [15:0] randBcd(input int unsigned lo,
                                           input int unsigned hi);
      return bcd($urandom_range(hi, lo));
   endfunction

   task automatic modelReset();
      kEdge = 0;
      sEdge = 0;
      mReg  = 0;
   endtask

   // one clock: apply dv, predict the outputs after the edge, compare at negedge
   task automatic tick(input logic [15:0] dv, input string tag);
      int unsigned idx, ph, nib, nm;
      logic        vis;
      logic [3:0]  expAn;
      logic [6:0]  expSeg;
      d   = dv;
      idx = (kEdge / R) % 4;
      ph  = ((kEdge - sEdge) / H) % 4;
      vis = (mReg == 0) || (mReg == 1 && ph < 2) || (mReg == 2 && (ph % 2) == 0);
      nib = (dv >> (4 * idx)) & 16'hF;
      expSeg = (nib <= 9) ? segTbl[nib] : 7'b1111111;
      expAn  = ~(4'b0001 << idx);
      if (!vis) begin
         expAn  = 4'b1111;
         expSeg = 7'b1111111;
      end
      nm = classOf(dv);
      if (nm != mReg) begin
         mReg  = nm;
         sEdge = kEdge + 1;
      end
      kEdge++;
      @(posedge clk);
      @(negedge clk);
      checkVal({tag, ".an"}, {12'd0, an}, {12'd0, expAn});
      checkVal({tag, ".seg"}, {9'd0, seg}, {9'd0, expSeg});
      checkVal({tag, ".dp"}, {15'd0, dp}, 16'd1);
   endtask

   task automatic run(input logic [15:0] dv, input int unsigned n,
                      input string tag);
      for (int unsigned i = 0; i < n; i++) tick(dv, tag);
   endtask

   initial begin
      logic [15:0] rv;
      int unsigned sel;
      nChecks = 0;
      nErrors = 0;
      rst_n = 1'b0;
      d     = 16'h1234;
      modelReset();
      #23;
      checkVal("reset.an", {12'd0, an}, 16'h000F);
      checkVal("reset.seg", {9'd0, seg}, 16'h007F);
      checkVal("reset.dp", {15'd0, dp}, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run(16'h1234, 40, "steady");
      run(16'h0199, 160, "low");
      run(16'h0000, 80, "zero");
      // switch LOW -> NORMAL while blanked, then back to LOW
      run(16'h0199, 50, "chg.low");
      run(16'h0200, 60, "chg.norm");
      run(16'h0150, 100, "chg.low2");
      run(16'h12A4, 40, "invalid");

      // asynchronous reset between edges, partway through a slot
      run(16'h4321, 6, "prerst");
      #2 rst_n = 1'b0;
      #1;
      checkVal("arst.an", {12'd0, an}, 16'h000F);
      checkVal("arst.seg", {9'd0, seg}, 16'h007F);
      checkVal("arst.dp", {15'd0, dp}, 16'd1);
      modelReset();
      #1 rst_n = 1'b1;
      run(16'h4321, 20, "postrst");

      // random segments biased toward the blink classes and invalid digits
      for (int unsigned seg_i = 0; seg_i < 40; seg_i++) begin
         sel = $urandom_range(4, 0);
         case (sel)
            0: rv = 16'h0000;
            1: rv = randBcd(1, 199);
            2: rv = randBcd(200, 9999);
            3: rv = 16'($urandom);
            default: rv = {4'd0, 4'($urandom_range(1, 0)), 8'($urandom)};
         endcase
         run(rv, $urandom_range(90, 3), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/meter_display.md
Name: meter_display

Overview:
- Downstream consumer of the parking-meter counter's 16-bit BCD time value (4 digits, 0000–9999).
- Drives the board's 4-digit common-anode seven-segment display by time-multiplexing the digits.
- Applies meter blink policy: steady when time ≥ 200, 2 s-period blink when 1–199, 1 s-period blink at 0000.
- Fully synchronous to the system clock; all outputs registered.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit scan slot (1 ms at 100 MHz); must be ≥ 1.
- HALF_SEC, 50000000: clk cycles per half-second blink tick; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  16  BCD time from counter; d[3:0] ones, d[7:4] tens, d[11:8] hundreds, d[15:12] thousands.
- an  output  4  digit anodes, active low; an[0] = ones (rightmost).
- seg  output  7  segments, active low, seg[6:0] = {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active low; always 1 (off) outside reset.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Scan index=0, scan counter=0, half-second counter=0, phase=2'b00, mode=NORMAL.
- Scan counter: counts 0..REFRESH_DIV-1 and wraps. On wrap, the 2-bit scan index increments (3→0 wrap).
- Output stage:
  - Each cycle, an/seg register the decode of the current scan index and current d.
  - Latency is 1 cycle from an index or d change to the outputs.
- Decode, applied to the selected nibble:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 gives seg=1111111 (blank digit). Its anode is still driven.
- Mode, evaluated combinationally from d and registered every cycle:
  - ZERO: d==16'h0000.
  - LOW: d!=0 and d[15:12]==0 and d[11:8]<2, i.e. BCD value 1–199.
  - NORMAL: otherwise, including d with invalid nibbles.
- Half-second counter: counts 0..HALF_SEC-1. On wrap, phase (2-bit) increments and wraps.
- Mode change: when the registered mode differs from the newly computed mode, the half-second counter and phase clear to 0 in the same cycle the mode register updates. Each blink sequence therefore starts in its visible interval.
- Visibility:
  - NORMAL: always visible.
  - LOW: visible when phase[1]==0 (1 s on, 1 s off).
  - ZERO: visible when phase[0]==0 (0.5 s on, 0.5 s off).
- Not visible: an=1111 and seg=1111111. Scan index keeps advancing, so scanning resumes at whatever digit is current.
- Input handling: d changes mid-scan are tolerated; each slot displays the digit value sampled that cycle. No glitch filtering.
- Reset mid-operation: all state returns to reset values immediately, with no wait for clk. First visible digit is ones, one cycle after the first clk edge following deassertion.

Test Plan:
Bench uses REFRESH_DIV=4, HALF_SEC=20.
- Steady display: reset, d=16'h1234, run 40 cycles.
  - an cycles 1110→1101→1011→0111, each held 4 cycles.
  - seg at the matching slots: 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - No blanking.
- LOW blink: d=16'h0199.
  - Visible (an≠1111) for 40 cycles, then an=1111 for 40 cycles, repeating.
  - Ones slot seg=0010000 (9).
- ZERO blink: d=16'h0000.
  - Visible 20 cycles, blank 20 cycles, repeating.
  - Visible slots all seg=1000000.
- Mode change restarts phase:
  - d=16'h0199 during a blank interval, switch to d=16'h0200.
  - Display visible within 2 cycles and stays visible.
  - Switch back to 16'h0150: visible for a full 40 cycles before blanking.
- Invalid nibble: d=16'h12A4.
  - Tens slot (an=1101) gives seg=1111111. Other slots decode normally.
  - Mode NORMAL, no blink.
- Async reset: assert rst_n=0 mid-slot, between clk edges.
  - an=1111, seg=1111111 immediately.
  - After release: ones slot active (an=1110) after the first clk edge.
